// File: rtl/port_sram_match_pkg.sv
// Shared types and default sizing for the per-port SRAM match engine.
package port_sram_match_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE,
        COOL
    } state_e;

    localparam int unsigned NUM_SRAM_DEF = 32;
    localparam int unsigned FREE_W_DEF   = 11;
    localparam int unsigned SRAM_IDX_W   = $clog2(NUM_SRAM_DEF);

    // Candidate ranking: bank preference dominates, then free-cell count.
    typedef struct packed {
        logic                  pref;
        logic [FREE_W_DEF-1:0] free;
    } score_t;

endpackage

// File: rtl/port_sram_group_picker.sv
// Combinational best-of-group selector over SCAN_WIDTH consecutive SRAM banks.
module sram_group_picker #(
    parameter int unsigned SCAN_WIDTH = 2,
    parameter int unsigned FREE_W     = 11,
    parameter int unsigned IDX_W      = 5
) (
    input  logic [IDX_W-1:0]             base_i,
    input  logic [SCAN_WIDTH*FREE_W-1:0] free_i,
    input  logic [SCAN_WIDTH-1:0]        locked_i,
    input  logic [SCAN_WIDTH-1:0]        pref_i,
    input  logic [8:0]                   length_i,
    output logic                         valid_o,
    output logic [IDX_W-1:0]             idx_o,
    output logic [FREE_W:0]              score_o
);

    localparam int unsigned CW = (FREE_W > 9) ? FREE_W : 9;

    always_comb begin
        logic [FREE_W-1:0] f;
        logic [FREE_W:0]   s;
        valid_o = 1'b0;
        idx_o   = base_i;
        score_o = '0;
        f       = '0;
        s       = '0;
        // Strict compare keeps the earliest bank on ties.
        for (int unsigned j = 0; j < SCAN_WIDTH; j++) begin
            f = free_i[j*FREE_W +: FREE_W];
            s = {pref_i[j], f};
            if (!locked_i[j] && (CW'(f) >= CW'(length_i)) && (!valid_o || (s > score_o))) begin
                valid_o = 1'b1;
                idx_o   = base_i + IDX_W'(j);
                score_o = s;
            end
        end
    end

endmodule

// File: rtl/port_sram_match_engine.sv
// Per-ingress-port SRAM matcher: round-robin group scan, running best candidate,
// accept after a threshold dwell or fail on timeout.
module port_sram_match_engine
    import port_sram_match_pkg::*;
#(
    parameter int unsigned PORT_IDX   = 0,
    parameter int unsigned NUM_SRAM   = 32,
    parameter int unsigned SCAN_WIDTH = 2,
    parameter int unsigned FREE_W     = 11
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [7:0]                                    threshold,
    input  logic [7:0]                                    timeout,
    input  logic                                          match_req,
    input  logic [3:0]                                    new_dest_port,
    input  logic [2:0]                                    new_prior,
    input  logic [8:0]                                    new_length,
    input  logic [NUM_SRAM*FREE_W-1:0]                    sram_free,
    input  logic [NUM_SRAM-1:0]                           sram_locked,
    input  logic [NUM_SRAM-1:0]                           sram_has_port,
    output logic                                          match_busy,
    output logic                                          match_done,
    output logic                                          match_ok,
    output logic [((NUM_SRAM > 1) ? $clog2(NUM_SRAM) : 1)-1:0] matched_sram,
    output logic [2:0]                                    matched_prior
);

    localparam int unsigned IDX_W = (NUM_SRAM > 1) ? $clog2(NUM_SRAM) : 1;
    localparam int unsigned START = (PORT_IDX * SCAN_WIDTH) % NUM_SRAM;
    localparam int unsigned CW    = (FREE_W > 9) ? FREE_W : 9;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [7:0]          tick_q, tick_d;
    logic                cand_valid_q, cand_valid_d;
    logic [IDX_W-1:0]    cand_idx_q, cand_idx_d;
    logic [8:0]          len_q, len_d;
    logic [3:0]          dest_q, dest_d;
    logic [2:0]          prior_q, prior_d;
    logic                ok_q, ok_d;
    logic [IDX_W-1:0]    msram_q, msram_d;

    logic [SCAN_WIDTH*FREE_W-1:0] grp_free;
    logic [SCAN_WIDTH-1:0]        grp_locked, grp_pref;
    logic                         grp_valid;
    logic [IDX_W-1:0]             grp_idx;
    logic [FREE_W:0]              grp_score;
    logic [FREE_W-1:0]            inc_free;
    logic [FREE_W:0]              inc_score;
    logic                         inc_ok;
    logic                         dest_unused;

    // Destination is held with the packet; bank preference arrives pre-decoded on sram_has_port.
    assign dest_unused = ^dest_q;

    always_comb begin
        logic [IDX_W-1:0] b;
        grp_free   = '0;
        grp_locked = '0;
        grp_pref   = '0;
        b          = '0;
        for (int unsigned j = 0; j < SCAN_WIDTH; j++) begin
            b = ptr_q + IDX_W'(j);
            grp_free[j*FREE_W +: FREE_W] = sram_free[(32'(ptr_q) + j)*FREE_W +: FREE_W];
            grp_locked[j] = sram_locked[b];
            grp_pref[j]   = sram_has_port[b];
        end
    end

    sram_group_picker #(
        .SCAN_WIDTH (SCAN_WIDTH),
        .FREE_W     (FREE_W),
        .IDX_W      (IDX_W)
    ) u_picker (
        .base_i   (ptr_q),
        .free_i   (grp_free),
        .locked_i (grp_locked),
        .pref_i   (grp_pref),
        .length_i (len_q),
        .valid_o  (grp_valid),
        .idx_o    (grp_idx),
        .score_o  (grp_score)
    );

    // Incumbent is always judged on live inputs, never on a stale stored score.
    assign inc_free  = sram_free[cand_idx_q*FREE_W +: FREE_W];
    assign inc_score = {sram_has_port[cand_idx_q], inc_free};
    assign inc_ok    = cand_valid_q && !sram_locked[cand_idx_q] && (CW'(inc_free) >= CW'(len_q));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        tick_d       = tick_q;
        cand_valid_d = cand_valid_q;
        cand_idx_d   = cand_idx_q;
        len_d        = len_q;
        dest_d       = dest_q;
        prior_d      = prior_q;
        ok_d         = ok_q;
        msram_d      = msram_q;
        case (state_q)
            IDLE: begin
                if (match_req) begin
                    state_d      = SCAN;
                    len_d        = new_length;
                    dest_d       = new_dest_port;
                    prior_d      = new_prior;
                    ptr_d        = IDX_W'(START);
                    tick_d       = '0;
                    cand_valid_d = 1'b0;
                    ok_d         = 1'b0;
                end
            end
            SCAN: begin
                if ((tick_q >= threshold) && inc_ok) begin
                    state_d = DONE;
                    ok_d    = 1'b1;
                    msram_d = cand_idx_q;
                end else if (tick_q >= timeout) begin
                    state_d = DONE;
                    ok_d    = 1'b0;
                    msram_d = '0;
                end else begin
                    if (grp_valid && (!inc_ok || (grp_score > inc_score))) begin
                        cand_valid_d = 1'b1;
                        cand_idx_d   = grp_idx;
                    end else begin
                        cand_valid_d = inc_ok;
                    end
                    ptr_d  = ((32'(ptr_q) + SCAN_WIDTH) >= NUM_SRAM) ? '0 : ptr_q + IDX_W'(SCAN_WIDTH);
                    tick_d = (tick_q == 8'hFF) ? tick_q : tick_q + 8'd1;
                end
            end
            DONE:    state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            tick_q       <= '0;
            cand_valid_q <= 1'b0;
            cand_idx_q   <= '0;
            len_q        <= '0;
            dest_q       <= '0;
            prior_q      <= '0;
            ok_q         <= 1'b0;
            msram_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tick_q       <= tick_d;
            cand_valid_q <= cand_valid_d;
            cand_idx_q   <= cand_idx_d;
            len_q        <= len_d;
            dest_q       <= dest_d;
            prior_q      <= prior_d;
            ok_q         <= ok_d;
            msram_q      <= msram_d;
        end
    end

    assign match_busy    = (state_q != IDLE);
    assign match_done    = (state_q == DONE);
    assign match_ok      = ok_q;
    assign matched_sram  = msram_q;
    assign matched_prior = prior_q;

endmodule

// File: tb/tb_port_sram_match_engine.sv
// Directed bench for port_sram_match_engine: two instances (PORT_IDX 0 and 15) on shared inputs.
module tb_port_sram_match_engine;

    logic          clk;
    logic          rst_n;
    logic [7:0]    threshold;
    logic [7:0]    timeout;
    logic          match_req;
    logic [3:0]    new_dest_port;
    logic [2:0]    new_prior;
    logic [8:0]    new_length;
    logic [351:0]  sram_free;
    logic [31:0]   sram_locked;
    logic [31:0]   sram_has_port;

    logic          match_busy, match_done, match_ok;
    logic [4:0]    matched_sram;
    logic [2:0]    matched_prior;
    logic          busy15, done15, ok15;
    logic [4:0]    msram15;
    logic [2:0]    prior15;

    int unsigned   checks = 0;
    int unsigned   errors = 0;

    port_sram_match_engine #(.PORT_IDX(0), .NUM_SRAM(32), .SCAN_WIDTH(2), .FREE_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .threshold(threshold), .timeout(timeout),
        .match_req(match_req), .new_dest_port(new_dest_port), .new_prior(new_prior),
        .new_length(new_length), .sram_free(sram_free), .sram_locked(sram_locked),
        .sram_has_port(sram_has_port), .match_busy(match_busy), .match_done(match_done),
        .match_ok(match_ok), .matched_sram(matched_sram), .matched_prior(matched_prior)
    );

    port_sram_match_engine #(.PORT_IDX(15), .NUM_SRAM(32), .SCAN_WIDTH(2), .FREE_W(11)) dut15 (
        .clk(clk), .rst_n(rst_n), .threshold(threshold), .timeout(timeout),
        .match_req(match_req), .new_dest_port(new_dest_port), .new_prior(new_prior),
        .new_length(new_length), .sram_free(sram_free), .sram_locked(sram_locked),
        .sram_has_port(sram_has_port), .match_busy(busy15), .match_done(done15),
        .match_ok(ok15), .matched_sram(msram15), .matched_prior(prior15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_free(input logic [10:0] v);
        for (int i = 0; i < 32; i++) sram_free[i*11 +: 11] = v;
    endtask

    task automatic start_req();
        @(negedge clk);
        match_req = 1'b1;
        tick();
        match_req = 1'b0;
    endtask

    // Edges after the request edge until match_done is seen; 999 when the bound expires.
    task automatic run_until_done(output int unsigned edges);
        edges = 999;
        for (int unsigned n = 1; n <= 300; n++) begin
            tick();
            if (match_done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (match_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", match_busy); end
        checks++; if (match_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", match_done); end
        checks++; if (match_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %0b expected 0", match_ok); end
        checks++; if (matched_sram !== 5'd0) begin errors++; $display("FAIL reset_sram: got %0d expected 0", matched_sram); end
        checks++; if (matched_prior !== 3'd0) begin errors++; $display("FAIL reset_prior: got %0d expected 0", matched_prior); end
        checks++; if (busy15 !== 1'b0) begin errors++; $display("FAIL reset_busy15: got %0b expected 0", busy15); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int unsigned e;
        set_all_free(11'd100);
        new_length = 9'd10; threshold = 8'd4; timeout = 8'd200; new_prior = 3'd5;
        start_req();
        checks++; if (match_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", match_busy); end
        checks++; if (matched_prior !== 3'd5) begin errors++; $display("FAIL basic_prior: got %0d expected 5", matched_prior); end
        run_until_done(e);
        checks++; if (e !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", e); end
        checks++; if (match_ok !== 1'b1) begin errors++; $display("FAIL basic_ok: got %0b expected 1", match_ok); end
        checks++; if (matched_sram !== 5'd0) begin errors++; $display("FAIL basic_sram: got %0d expected 0", matched_sram); end
        checks++; if (msram15 !== 5'd30) begin errors++; $display("FAIL basic_sram15: got %0d expected 30", msram15); end
        tick();
        checks++; if (match_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b expected 0", match_done); end
        checks++; if (match_busy !== 1'b1) begin errors++; $display("FAIL basic_cool_busy: got %0b expected 1", match_busy); end
        tick();
        checks++; if (match_busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0b expected 0", match_busy); end
        settle();
    endtask

    task automatic test_preference();
        int unsigned e;
        set_all_free(11'd500);
        sram_free[7*11 +: 11] = 11'd20;
        sram_has_port = 32'h0000_0080;
        threshold = 8'd16;
        start_req();
        run_until_done(e);
        checks++; if (e !== 17) begin errors++; $display("FAIL pref_latency: got %0d expected 17", e); end
        checks++; if (matched_sram !== 5'd7) begin errors++; $display("FAIL pref_sram: got %0d expected 7", matched_sram); end
        checks++; if (msram15 !== 5'd7) begin errors++; $display("FAIL pref_sram15: got %0d expected 7", msram15); end
        sram_has_port = '0;
        settle();
    endtask

    task automatic test_revalidation();
        int unsigned e;
        set_all_free(11'd100);
        sram_has_port = 32'h0000_0008;
        threshold = 8'd4;
        start_req();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (match_done !== 1'b0) begin errors++; $display("FAIL reval_early_done: got %0b expected 0", match_done); end
        end
        sram_locked[3] = 1'b1;
        run_until_done(e);
        checks++; if (e !== 2) begin errors++; $display("FAIL reval_latency: got %0d expected 2", e); end
        checks++; if (match_ok !== 1'b1) begin errors++; $display("FAIL reval_ok: got %0b expected 1", match_ok); end
        checks++; if (matched_sram !== 5'd8) begin errors++; $display("FAIL reval_sram: got %0d expected 8", matched_sram); end
        checks++; if (msram15 !== 5'd6) begin errors++; $display("FAIL reval_sram15: got %0d expected 6", msram15); end
        sram_locked = '0;
        sram_has_port = '0;
        settle();
    endtask

    task automatic test_timeout();
        int unsigned e;
        set_all_free(11'd5);
        threshold = 8'd4; timeout = 8'd20;
        start_req();
        run_until_done(e);
        checks++; if (e !== 21) begin errors++; $display("FAIL timeout_latency: got %0d expected 21", e); end
        checks++; if (match_ok !== 1'b0) begin errors++; $display("FAIL timeout_ok: got %0b expected 0", match_ok); end
        checks++; if (matched_sram !== 5'd0) begin errors++; $display("FAIL timeout_sram: got %0d expected 0", matched_sram); end
        checks++; if (ok15 !== 1'b0) begin errors++; $display("FAIL timeout_ok15: got %0b expected 0", ok15); end
        timeout = 8'd200;
        settle();
    endtask

    task automatic test_wrap_offset();
        int unsigned e0, e15;
        set_all_free(11'd5);
        sram_free[1*11 +: 11] = 11'd50;
        threshold = 8'd0;
        e0 = 0; e15 = 0;
        start_req();
        for (int unsigned n = 1; n <= 20; n++) begin
            tick();
            if (match_done && e0 == 0) e0 = n;
            if (done15 && e15 == 0) e15 = n;
            if (e0 != 0 && e15 != 0) break;
        end
        checks++; if (e0 !== 2) begin errors++; $display("FAIL wrap_latency0: got %0d expected 2", e0); end
        checks++; if (e15 !== 3) begin errors++; $display("FAIL wrap_latency15: got %0d expected 3", e15); end
        checks++; if (msram15 !== 5'd1) begin errors++; $display("FAIL wrap_sram15: got %0d expected 1", msram15); end
        checks++; if (ok15 !== 1'b1) begin errors++; $display("FAIL wrap_ok15: got %0b expected 1", ok15); end
        checks++; if (matched_sram !== 5'd1) begin errors++; $display("FAIL wrap_sram0: got %0d expected 1", matched_sram); end
        settle();
    endtask

    task automatic test_reset_mid_scan();
        set_all_free(11'd100);
        threshold = 8'd50; new_prior = 3'd3;
        start_req();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++; if (match_busy !== 1'b0) begin errors++; $display("FAIL rst_scan_busy: got %0b expected 0", match_busy); end
        checks++; if (match_ok !== 1'b0) begin errors++; $display("FAIL rst_scan_ok: got %0b expected 0", match_ok); end
        checks++; if (matched_sram !== 5'd0) begin errors++; $display("FAIL rst_scan_sram: got %0d expected 0", matched_sram); end
        checks++; if (matched_prior !== 3'd0) begin errors++; $display("FAIL rst_scan_prior: got %0d expected 0", matched_prior); end
        checks++; if (match_done !== 1'b0) begin errors++; $display("FAIL rst_scan_done: got %0b expected 0", match_done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cool_ignore();
        int unsigned e;
        set_all_free(11'd100);
        threshold = 8'd0; new_prior = 3'd2;
        start_req();
        run_until_done(e);
        checks++; if (e !== 2) begin errors++; $display("FAIL cool_latency: got %0d expected 2", e); end
        tick();
        checks++; if (match_busy !== 1'b1) begin errors++; $display("FAIL cool_busy: got %0b expected 1", match_busy); end
        match_req = 1'b1; new_prior = 3'd6;
        tick();
        match_req = 1'b0;
        checks++; if (match_busy !== 1'b0) begin errors++; $display("FAIL cool_ignored_busy: got %0b expected 0", match_busy); end
        checks++; if (matched_prior !== 3'd2) begin errors++; $display("FAIL cool_prior: got %0d expected 2", matched_prior); end
        tick();
        checks++; if (match_busy !== 1'b0) begin errors++; $display("FAIL cool_no_queue: got %0b expected 0", match_busy); end
        settle();
    endtask

    initial begin
        rst_n = 1'b0; match_req = 1'b0; threshold = '0; timeout = 8'd200;
        new_dest_port = 4'd3; new_prior = '0; new_length = 9'd10;
        sram_free = '0; sram_locked = '0; sram_has_port = '0;
        test_reset();
        test_basic();
        test_preference();
        test_revalidation();
        test_timeout();
        test_wrap_offset();
        test_reset_mid_scan();
        test_cool_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
